rambyte_arb: RTL and testbench

- Round-robin arbiter and sequencer that shares one single-port, byte-masked, read-first synchronous RAM (1-cycle read latency) between NR requesters.
- After reset, an init sweep zero-fills the RAM, then the block accepts at most one request per cycle via valid/ready.
- Routes each read response back to its requester with a one-hot response strobe. Sits between bus-side clients and the RAM macro.

---
 rtl/rambyte_arb_pkg.sv | 26 ++
 rtl/rambyte_arb_rr.sv | 26 ++
 rtl/rambyte_arb.sv | 141 ++++++++++++++
 tb/tb_rambyte_arb.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/rambyte_arb_pkg.sv
// Shared types and the round-robin pick function for the rambyte RAM arbiter.
package rambyte_arb_pkg;

  typedef enum logic {INIT, RUN} state_t;

  localparam int NR_MAX = 8;

  // One-hot grant: first valid requester at or after ptr, wrapping mod nr.
  function automatic logic [NR_MAX-1:0] rr_pick(input logic [NR_MAX-1:0] valid,
                                                input logic [2:0] ptr,
                                                input int nr);
    logic [NR_MAX-1:0] g;
    logic [3:0] idx;
    g = '0;
    // Walk backwards so the lowest rotated position wins.
    for (int k = NR_MAX - 1; k >= 0; k--) begin
      if (k < nr) begin
        idx = {1'b0, ptr} + 4'(k);
        if (idx >= 4'(nr)) idx = idx - 4'(nr);
        if (valid[idx[2:0]]) g = NR_MAX'(1) << idx;
      end
    end
    return g;
  endfunction

endpackage

// File: rtl/rambyte_arb_rr.sv
// NR-way round-robin picker: one-hot grant plus its binary index.
module rambyte_arb_rr
  import rambyte_arb_pkg::*;
#(
  parameter int NR = 4,
  parameter int IW = $clog2(NR)
) (
  input  logic [NR-1:0] valid,
  input  logic [IW-1:0] ptr,
  output logic [NR-1:0] grant,
  output logic [IW-1:0] idx,
  output logic          any
);

  logic [NR_MAX-1:0] g8;

  always_comb begin
    g8    = rr_pick(NR_MAX'(valid), 3'(ptr), NR);
    grant = g8[NR-1:0];
    any   = |g8;
    idx   = '0;
    for (int i = 0; i < NR; i++)
      if (grant[i]) idx = IW'(i);
  end

endmodule

// File: rtl/rambyte_arb.sv
// Round-robin sharing of one byte-masked read-first RAM with a zero-fill init sweep.
// Define RAMBYTE_ARB_OUTREG_EN to add an output register stage (2-cycle response latency).
module rambyte_arb
  import rambyte_arb_pkg::*;
#(
  parameter int DW = 16,
  parameter int AW = 10,
  parameter int NR = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NR-1:0]        req_valid,
  output logic [NR-1:0]        req_ready,
  input  logic [NR*DW/8-1:0]   req_we,
  input  logic [NR*AW-1:0]     req_addr,
  input  logic [NR*DW-1:0]     req_din,
  output logic [NR-1:0]        rsp_valid,
  output logic [DW-1:0]        rsp_dout,
  output logic                 init_done,
  output logic                 ram_ce,
  output logic [DW/8-1:0]      ram_we,
  output logic [AW-1:0]        ram_addr,
  output logic [DW-1:0]        ram_din,
  input  logic [DW-1:0]        ram_dout
);

  localparam int NB = DW / 8;
  localparam int IW = $clog2(NR);
  localparam logic [AW-1:0] LAST = '1;

  state_t          state, state_nx;
  logic [AW-1:0]   cnt, addr_q;
  logic [DW-1:0]   din_q, dout_q;
  logic [IW-1:0]   ptr, gidx;
  logic [NR-1:0]   grant, tag;
  logic            any, active;
  logic [NB-1:0]   sel_we;
  logic [AW-1:0]   sel_addr;
  logic [DW-1:0]   sel_din;

  // rst masks arbitration within the same cycle so nothing is accepted while it is high.
  assign active = (state == RUN) && !rst;

  rambyte_arb_rr #(.NR(NR), .IW(IW)) u_rr (
    .valid (req_valid & {NR{active}}),
    .ptr   (ptr),
    .grant (grant),
    .idx   (gidx),
    .any   (any)
  );

  always_comb begin
    sel_we   = '0;
    sel_addr = '0;
    sel_din  = '0;
    for (int i = 0; i < NR; i++)
      if (grant[i]) begin
        sel_we   = req_we[i*NB +: NB];
        sel_addr = req_addr[i*AW +: AW];
        sel_din  = req_din[i*DW +: DW];
      end
  end

  always_comb begin
    state_nx  = state;
    req_ready = '0;
    ram_ce    = 1'b0;
    ram_we    = '0;
    ram_addr  = addr_q;
    ram_din   = din_q;
    case (state)
      INIT: begin
        ram_ce   = 1'b1;
        ram_we   = '1;
        ram_din  = '0;
        ram_addr = cnt;
        if (cnt == LAST) state_nx = RUN;
      end
      RUN: if (any) begin
        req_ready = grant;
        ram_ce    = 1'b1;
        ram_we    = sel_we;
        ram_addr  = sel_addr;
        ram_din   = sel_din;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= INIT;
      cnt    <= '0;
      ptr    <= '0;
      tag    <= '0;
      addr_q <= '0;
      din_q  <= '0;
    end else begin
      state <= state_nx;
      tag   <= grant;
      if (state == INIT) cnt <= cnt + 1'b1;
      if (any) ptr <= (gidx == IW'(NR - 1)) ? '0 : gidx + 1'b1;
      if (ram_ce) begin
        addr_q <= ram_addr;
        din_q  <= ram_din;
      end
    end
  end

  assign init_done = (state == RUN);

`ifdef RAMBYTE_ARB_OUTREG_EN
  logic [NR-1:0] tag2;

  always_ff @(posedge clk) begin
    if (rst) begin
      tag2   <= '0;
      dout_q <= '0;
    end else begin
      tag2 <= tag;
      if (|tag) dout_q <= ram_dout;
    end
  end

  assign rsp_valid = tag2 & {NR{~rst}};
  assign rsp_dout  = dout_q;
`else
  logic [NR-1:0] tag_v;

  assign tag_v = tag & {NR{~rst}};

  // Hold register keeps rsp_dout stable between responses.
  always_ff @(posedge clk) begin
    if (rst)        dout_q <= '0;
    else if (|tag)  dout_q <= ram_dout;
  end

  assign rsp_valid = tag_v;
  assign rsp_dout  = (|tag_v) ? ram_dout : dout_q;
`endif

endmodule

// File: tb/tb_rambyte_arb.sv
// Bench for rambyte_arb with a behavioural byte-masked read-first RAM and a shadow-memory model.
module tb_rambyte_arb;

  localparam int DW = 16, AW = 4, NR = 4, NB = 2, DEPTH = 16;
`ifdef RAMBYTE_ARB_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic                 clk, rst;
  logic [NR-1:0]        req_valid, req_ready, rsp_valid;
  logic [NR*NB-1:0]     req_we;
  logic [NR*AW-1:0]     req_addr;
  logic [NR*DW-1:0]     req_din;
  logic [DW-1:0]        rsp_dout, ram_din, ram_dout;
  logic                 init_done, ram_ce;
  logic [NB-1:0]        ram_we;
  logic [AW-1:0]        ram_addr;

  rambyte_arb #(.DW(DW), .AW(AW), .NR(NR)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_din(req_din),
    .rsp_valid(rsp_valid), .rsp_dout(rsp_dout), .init_done(init_done),
    .ram_ce(ram_ce), .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din),
    .ram_dout(ram_dout)
  );

  always #5 clk = ~clk;

  // Read-first byte-masked RAM.
  logic [DW-1:0] mem [DEPTH];
  always @(posedge clk)
    if (ram_ce) begin
      ram_dout <= mem[ram_addr];
      for (int b = 0; b < NB; b++)
        if (ram_we[b]) mem[ram_addr][b*8 +: 8] <= ram_din[b*8 +: 8];
    end

  int total, bad;
  bit            v [NR];
  logic [NB-1:0] we [NR];
  logic [AW-1:0] ad [NR];
  logic [DW-1:0] dn [NR];
  logic [DW-1:0] shadow [DEPTH];
  bit            pv [LAT];
  int            pi [LAT];
  logic [DW-1:0] pd [LAT];
  int            ptr, init_left, mode, last_grant;
  logic [NR-1:0] mask;
  logic [DW-1:0] last_dout, obs_dout;
  int            gs [8];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic newrand(input int i);
    ad[i] = AW'($urandom_range(0, DEPTH - 1));
    we[i] = ($urandom_range(0, 1) == 0) ? 2'b00 : NB'($urandom_range(1, 3));
    dn[i] = DW'($urandom);
  endtask

  task automatic next_txn(input int i);
    if (mode == 0) v[i] = 0;
    else if (mode == 1) begin newrand(i); v[i] = mask[i]; end
    else begin newrand(i); v[i] = ($urandom_range(0, 1) == 1); end
  endtask

  task automatic step(input bit r);
    int g;
    logic [NR-1:0] exp_rdy, exp_v;
    logic [DW-1:0] exp_d;
    rst = r;
    for (int i = 0; i < NR; i++) begin
      req_valid[i]            = v[i];
      req_we[i*NB +: NB]      = we[i];
      req_addr[i*AW +: AW]    = ad[i];
      req_din[i*DW +: DW]     = dn[i];
    end
    @(negedge clk);
    g = -1;
    if (!r && init_left == 0)
      for (int k = 0; k < NR; k++)
        if (g < 0 && v[(ptr + k) % NR]) g = (ptr + k) % NR;
    exp_rdy = (g >= 0) ? NR'(1 << g) : '0;
    chk("ready", req_ready, exp_rdy);
    if (!r) begin
      chk("init_done", init_done, (init_left == 0));
      exp_v = pv[LAT-1] ? NR'(1 << pi[LAT-1]) : '0;
      exp_d = pv[LAT-1] ? pd[LAT-1] : last_dout;
      chk("rsp_valid", rsp_valid, exp_v);
      chk("rsp_dout", rsp_dout, exp_d);
      if (pv[LAT-1]) last_dout = pd[LAT-1];
      if (rsp_valid != 0) obs_dout = rsp_dout;
      if (init_left > 0) begin
        chk("init_ce", ram_ce, 1);
        chk("init_we", ram_we, 2'b11);
        chk("init_addr", ram_addr, DEPTH - init_left);
        chk("init_din", ram_din, 0);
      end
    end else chk("rst_rsp", rsp_valid, 0);
    last_grant = g;
    if (r) begin
      init_left = DEPTH; ptr = 0; last_dout = '0;
      for (int k = 0; k < LAT; k++) pv[k] = 0;
      for (int a = 0; a < DEPTH; a++) shadow[a] = '0;
      for (int i = 0; i < NR; i++) v[i] = 0;
    end else begin
      for (int k = LAT - 1; k > 0; k--) begin pv[k] = pv[k-1]; pi[k] = pi[k-1]; pd[k] = pd[k-1]; end
      pv[0] = (g >= 0);
      if (g >= 0) begin
        pi[0] = g;
        pd[0] = shadow[ad[g]];
        for (int b = 0; b < NB; b++)
          if (we[g][b]) shadow[ad[g]][b*8 +: 8] = dn[g][b*8 +: 8];
        ptr = (g + 1) % NR;
        next_txn(g);
      end
      if (mode == 2)
        for (int i = 0; i < NR; i++)
          if (!v[i] && i != g && $urandom_range(0, 2) == 0) begin newrand(i); v[i] = 1; end
      if (init_left > 0) init_left--;
    end
    @(posedge clk); #1;
  endtask

  task automatic idle_all();
    mode = 0;
    for (int i = 0; i < NR; i++) v[i] = 0;
  endtask

  task automatic do_txn(input int i, input logic [NB-1:0] w, input logic [AW-1:0] a,
                        input logic [DW-1:0] d);
    int n;
    bit acc;
    idle_all();
    v[i] = 1; we[i] = w; ad[i] = a; dn[i] = d;
    obs_dout = 'x;
    n = 0; acc = 0;
    while (!acc && n < 10) begin step(0); acc = (last_grant == i); n++; end
    if (!acc) chk("accept_timeout", 0, 1);
    repeat (LAT) step(0);
  endtask

  task automatic wait_init(input string tag);
    int n;
    n = 0;
    while (!init_done && n < 40) begin step(0); n++; end
    chk(tag, n, DEPTH);
  endtask

  initial begin
    clk = 0; rst = 1; total = 0; bad = 0; mode = 0; mask = '0;
    ptr = 0; init_left = DEPTH; last_dout = '0; obs_dout = '0; last_grant = -1;
    for (int i = 0; i < NR; i++) begin v[i] = 0; we[i] = '0; ad[i] = '0; dn[i] = '0; end
    for (int k = 0; k < LAT; k++) begin pv[k] = 0; pi[k] = 0; pd[k] = '0; end
    #1;
    step(1); step(1);
    wait_init("init_len");

    for (int a = 0; a < DEPTH; a++) begin
      do_txn(0, 2'b00, AW'(a), '0);
      chk("init_zero", obs_dout, 0);
    end

    do_txn(0, 2'b11, 4'd3, 16'hBEEF);
    chk("wr_old", obs_dout, 0);
    do_txn(0, 2'b00, 4'd3, '0);
    chk("beef", obs_dout, 16'hBEEF);

    do_txn(1, 2'b11, 4'd5, 16'h1234);
    do_txn(1, 2'b10, 4'd5, 16'hABCD);
    chk("mask_old", obs_dout, 16'h1234);
    do_txn(1, 2'b00, 4'd5, '0);
    chk("mask_rd", obs_dout, 16'hAB34);

    // All four continuously valid: grants must advance by one each cycle.
    mode = 1; mask = 4'hF;
    for (int i = 0; i < NR; i++) begin newrand(i); v[i] = 1; end
    for (int k = 0; k < 8; k++) begin step(0); gs[k] = last_grant; end
    for (int k = 1; k < 8; k++) chk("rotate", gs[k], (gs[k-1] + 1) % NR);
    idle_all(); repeat (LAT) step(0);

    // A grant to 1 leaves ptr at 2; then only 1 and 3 compete.
    do_txn(1, 2'b00, 4'd0, '0);
    mode = 1; mask = 4'b1010;
    v[1] = 1; v[3] = 1; newrand(1); newrand(3);
    for (int k = 0; k < 3; k++) begin step(0); gs[k] = last_grant; end
    chk("sparse0", gs[0], 3);
    chk("sparse1", gs[1], 1);
    chk("sparse2", gs[2], 3);
    idle_all(); repeat (LAT) step(0);

    mode = 2;
    for (int i = 0; i < NR; i++) begin newrand(i); v[i] = 1; end
    repeat (300) step(0);
    idle_all(); repeat (LAT) step(0);

    // Reset while a read response is still pending.
    do_txn(2, 2'b11, 4'd7, 16'h5A5A);
    v[2] = 1; we[2] = '0; ad[2] = 4'd7;
    step(0);
    chk("rst_accept", last_grant, 2);
    step(1);
    chk("rst_init_low", init_done, 0);
    wait_init("reinit_len");
    do_txn(0, 2'b00, 4'd7, '0);
    chk("rst_zero", obs_dout, 0);
    do_txn(0, 2'b00, 4'd3, '0);
    chk("rst_zero3", obs_dout, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
